// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing memory port between the instruction-fetch
// and data requesters. Only one transaction is in flight at a time. Data wins ties,
// but a starvation counter forces a fetch grant after STARVE_LIMIT consecutive
// data grants that left a fetch waiting.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_req_valid,
  input  logic [ADDR_W-1:0] imem_req_addr,
  output logic              imem_res_valid,
  output logic [DATA_W-1:0] imem_res_data,
  input  logic              dmem_req_valid,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_req_fcn,
  input  logic [2:0]        dmem_req_typ,
  output logic              dmem_res_valid,
  output logic [DATA_W-1:0] dmem_res_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic              mem_req_fcn,
  output logic [2:0]        mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic [1:0]        owner
);

  localparam int          CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [2:0]  MT_WU     = 3'd7;
  localparam logic [1:0]  OWN_NONE  = 2'b00;
  localparam logic [1:0]  OWN_IMEM  = 2'b01;
  localparam logic [1:0]  OWN_DMEM  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                fcn_q, fcn_d;
  logic [2:0]          typ_q, typ_d;

  logic                grant_imem;
  logic                grant_dmem;
  logic                resp_hit;

  // Arbitration is only meaningful in IDLE; fetch wins if alone or once starved.
  assign grant_imem = (state_q == S_IDLE) && imem_req_valid &&
                      (!dmem_req_valid || (starve_q == CNT_LIMIT));
  assign grant_dmem = (state_q == S_IDLE) && dmem_req_valid && !grant_imem;
  // A backing response only counts while a request is outstanding.
  assign resp_hit   = (state_q == S_WAIT) && mem_resp_valid;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> ISSUE on grant, ISSUE -> WAIT on accept, WAIT -> IDLE on response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_imem || grant_dmem) state_d = S_ISSUE;
      S_ISSUE: if (mem_req_ready)            state_d = S_WAIT;
      S_WAIT:  if (mem_resp_valid)           state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // Outputs: request valid in ISSUE, response passed straight through to the owner in WAIT.
  always_comb begin
    mem_req_valid  = (state_q == S_ISSUE);
    imem_res_valid = resp_hit && (owner_q == OWN_IMEM);
    dmem_res_valid = resp_hit && (owner_q == OWN_DMEM);
    imem_res_data  = imem_res_valid ? mem_resp_data : '0;
    dmem_res_data  = dmem_res_valid ? mem_resp_data : '0;
  end

  // Next values for owner, starvation counter and latched request fields.
  always_comb begin
    owner_d  = owner_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fcn_d    = fcn_q;
    typ_d    = typ_q;
    if (grant_imem) begin
      owner_d  = OWN_IMEM;
      starve_d = '0;
      addr_d   = imem_req_addr;
      wdata_d  = '0;
      fcn_d    = 1'b0;
      typ_d    = MT_WU;
    end else if (grant_dmem) begin
      owner_d  = OWN_DMEM;
      addr_d   = dmem_req_addr;
      wdata_d  = dmem_req_wdata;
      fcn_d    = dmem_req_fcn;
      typ_d    = dmem_req_typ;
      // Count only grants that left a fetch waiting; saturate defensively.
      if (!imem_req_valid)             starve_d = '0;
      else if (starve_q != CNT_LIMIT)  starve_d = starve_q + 1'b1;
    end else if (resp_hit) begin
      owner_d  = OWN_NONE;
    end
  end

  // Owner, counter and latched request fields; all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fcn_q    <= 1'b0;
      typ_q    <= 3'd0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fcn_q    <= fcn_d;
      typ_q    <= typ_d;
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_fcn   = fcn_q;
  assign mem_req_typ   = typ_q;
  assign owner         = owner_q;

endmodule
